ub_port_arbiter: RTL and testbench
==================================

Name: ub_port_arbiter

Overview:
- Arbitrates the unified buffer's single write port between two requesters: the host activation loader and the accumulator writeback path.
- Muxes the buffer's single read port between activation streaming from the control unit and host readout.
- Sits directly in front of unified_buffer. It drives that block's read_i, write_i, addr_rd, addr_wr and data-in.
- Write arbitration is round-robin with a bounded burst length, so neither write requester can starve the other.

Parameters:
- LANES, 32, number of 16-bit lanes per buffer row
- DATA_W, 16, lane width in bits
- ADDR_W, 12, buffer row address width
- MAX_BURST, 8, maximum consecutive write beats per grant (must be 2 or more)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- host_wr_req_i  in  1  host write request
- host_wr_addr_i  in  ADDR_W  host write row address
- host_wr_data_i  in  DATA_W x LANES  host write row
- host_wr_gnt_o  out  1  host write grant (registered)
- acc_wr_req_i  in  1  accumulator writeback request
- acc_wr_addr_i  in  ADDR_W  writeback row address
- acc_wr_data_i  in  DATA_W x LANES  writeback row
- acc_wr_gnt_o  out  1  writeback grant (registered)
- act_rd_i  in  1  activation read strobe from the control unit; never stalled
- act_rd_addr_i  in  ADDR_W  activation read address
- host_rd_req_i  in  1  host read request
- host_rd_addr_i  in  ADDR_W  host read address
- host_rd_gnt_o  out  1  host read grant (combinational)
- host_rd_valid_o  out  1  host read data valid on the buffer output
- ub_write_o  out  1  buffer write enable
- ub_addr_wr_o  out  ADDR_W  buffer write address
- ub_data_o  out  DATA_W x LANES  buffer write row
- ub_read_o  out  1  buffer read enable
- ub_addr_rd_o  out  ADDR_W  buffer read address
- rw_conflict_o  out  1  a read and a write were issued to the same address in the same cycle

Behaviour:
- Reset (rst_i low, asynchronous): all outputs other than the combinational read-path outputs go to 0 immediately.
  - FSM returns to IDLE; beat counter is cleared; last_served is set to ACC.
  - Any in-flight beat is dropped.
  - After release, arbitration restarts from IDLE. The first tie goes to host.
- Handshake:
  - A beat transfers in any cycle where req and gnt are both high.
  - A requester holds addr and data stable while req is high. It may drop req in any cycle.
  - A grant on a cycle where req is low transfers nothing.
- Write FSM states: IDLE, GNT_HOST, GNT_ACC. Grants are registered, so the first grant appears 1 cycle after req is seen.
- IDLE:
  - Host only requesting -> GNT_HOST.
  - Acc only requesting -> GNT_ACC.
  - Both requesting -> the requester that is not last_served.
  - Neither requesting -> stay in IDLE.
- GNT_x:
  - Each beat increments the beat counter.
  - req_x low -> re-arbitrate in the same cycle using the IDLE rules. This allows a direct switch to the other requester with no bubble.
  - Beat with count == MAX_BURST-1 and the other requester active -> switch to GNT_other, set last_served = x, clear the counter.
  - Beat with count == MAX_BURST-1 and the other requester idle -> stay in GNT_x, clear the counter.
- Write datapath latency is 1: a beat in cycle N gives ub_write_o=1 with that beat's address and data in cycle N+1.
- ub_write_o is 0 in any cycle not preceded by a beat.
- Read path (combinational, no FSM):
  - act_rd_i has absolute priority.
  - host_rd_gnt_o = host_rd_req_i & ~act_rd_i.
  - ub_read_o = act_rd_i | host_rd_gnt_o.
  - ub_addr_rd_o = act_rd_addr_i when act_rd_i is high, otherwise host_rd_addr_i.
- host_rd_valid_o is host_rd_gnt_o delayed 1 cycle, matching the buffer's 1-cycle read latency.
- rw_conflict_o is registered. It is 1 in cycle N+1 when, in cycle N, ub_write_o and ub_read_o were both 1 and ub_addr_wr_o == ub_addr_rd_o.
  - The buffer returns old data in that case. The flag is informational only.
- The beat counter is $clog2(MAX_BURST) bits wide and never exceeds MAX_BURST-1.

Test Plan:
- Reset mid-burst: host bursting at beat 3, rst_i pulled low -> all gnt outputs, ub_write_o and host_rd_valid_o go to 0 before the next clock edge. After release with both reqs high -> host granted first.
- Host-only burst: host req high for 20 cycles, addresses 0..19 -> host_wr_gnt_o rises 1 cycle after req. 20 ub_write_o pulses follow, each 1 cycle after its beat, with addresses 0..19 in order. acc_wr_gnt_o stays 0.
- Contention with MAX_BURST=8: both reqs held continuously -> grants alternate 8 host beats then 8 acc beats, with no idle cycle at switch points.
- Early release: acc granted, acc drops req after 3 beats while host is requesting -> host_wr_gnt_o high the next cycle. Exactly 3 acc writes appear on the buffer.
- Read priority: act_rd_i and host_rd_req_i both high for 4 cycles, then act_rd_i low -> host_rd_gnt_o=0 for those 4 cycles, then 1. host_rd_valid_o follows 1 cycle after the grant. ub_addr_rd_o tracks the act address during the overlap, then the host address.
- Conflict: write beat to address 0x010 in cycle N, act read of 0x010 in cycle N+1 -> rw_conflict_o=1 in cycle N+2 and 0 otherwise.

Source files
------------

// File: rtl/ub_port_arbiter.sv
// Unified buffer port arbiter: round-robin bounded-burst write arbitration between
// host loader and accumulator writeback, plus priority mux of the single read port.
module ub_port_arbiter #(
  parameter int unsigned LANES     = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      host_wr_req_i,
  input  logic [ADDR_W-1:0]         host_wr_addr_i,
  input  logic [LANES*DATA_W-1:0]   host_wr_data_i,
  output logic                      host_wr_gnt_o,
  input  logic                      acc_wr_req_i,
  input  logic [ADDR_W-1:0]         acc_wr_addr_i,
  input  logic [LANES*DATA_W-1:0]   acc_wr_data_i,
  output logic                      acc_wr_gnt_o,
  input  logic                      act_rd_i,
  input  logic [ADDR_W-1:0]         act_rd_addr_i,
  input  logic                      host_rd_req_i,
  input  logic [ADDR_W-1:0]         host_rd_addr_i,
  output logic                      host_rd_gnt_o,
  output logic                      host_rd_valid_o,
  output logic                      ub_write_o,
  output logic [ADDR_W-1:0]         ub_addr_wr_o,
  output logic [LANES*DATA_W-1:0]   ub_data_o,
  output logic                      ub_read_o,
  output logic [ADDR_W-1:0]         ub_addr_rd_o,
  output logic                      rw_conflict_o
);

  localparam int unsigned ROW_W = LANES * DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GNT_HOST, GNT_ACC} state_e;

  state_e             state_q, state_d, idle_pick;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_acc_q, last_acc_d;
  logic               host_gnt_q, acc_gnt_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [ROW_W-1:0]   wr_data_q;
  logic               rd_valid_q, conflict_q;
  logic               host_beat, acc_beat;

  assign host_beat = host_wr_req_i & host_gnt_q;
  assign acc_beat  = acc_wr_req_i & acc_gnt_q;

  // Write FSM state and registered grants
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_acc_q <= 1'b1;
      host_gnt_q <= 1'b0;
      acc_gnt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_acc_q <= last_acc_d;
      host_gnt_q <= (state_d == GNT_HOST);
      acc_gnt_q  <= (state_d == GNT_ACC);
    end
  end

  // Next state: idle rules on release, forced hand-over at the burst limit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_acc_d = last_acc_q;
    idle_pick  = IDLE;
    if (host_wr_req_i && acc_wr_req_i) idle_pick = last_acc_q ? GNT_HOST : GNT_ACC;
    else if (host_wr_req_i)            idle_pick = GNT_HOST;
    else if (acc_wr_req_i)             idle_pick = GNT_ACC;

    case (state_q)
      IDLE: begin
        state_d = idle_pick;
        cnt_d   = '0;
      end
      GNT_HOST: begin
        if (!host_wr_req_i) begin
          state_d    = idle_pick;
          cnt_d      = '0;
          last_acc_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (acc_wr_req_i) begin
            state_d    = GNT_ACC;
            last_acc_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GNT_ACC: begin
        if (!acc_wr_req_i) begin
          state_d    = idle_pick;
          cnt_d      = '0;
          last_acc_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (host_wr_req_i) begin
            state_d    = GNT_HOST;
            last_acc_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-cycle write datapath and read-side status flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_valid_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      wr_q <= host_beat | acc_beat;
      if (host_beat) begin
        wr_addr_q <= host_wr_addr_i;
        wr_data_q <= host_wr_data_i;
      end else if (acc_beat) begin
        wr_addr_q <= acc_wr_addr_i;
        wr_data_q <= acc_wr_data_i;
      end
      rd_valid_q <= host_rd_gnt_o;
      conflict_q <= wr_q & ub_read_o & (wr_addr_q == ub_addr_rd_o);
    end
  end

  assign host_rd_gnt_o   = host_rd_req_i & ~act_rd_i;
  assign ub_read_o       = act_rd_i | host_rd_gnt_o;
  assign ub_addr_rd_o    = act_rd_i ? act_rd_addr_i : host_rd_addr_i;

  assign host_wr_gnt_o   = host_gnt_q;
  assign acc_wr_gnt_o    = acc_gnt_q;
  assign ub_write_o      = wr_q;
  assign ub_addr_wr_o    = wr_addr_q;
  assign ub_data_o       = wr_data_q;
  assign host_rd_valid_o = rd_valid_q;
  assign rw_conflict_o   = conflict_q;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed bench for ub_port_arbiter: reset, bursts, contention, early release,
// read priority and read/write conflict flag.
module tb_ub_port_arbiter;

  localparam int unsigned LANES  = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned ROW_W  = LANES * DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              host_wr_req_i = 1'b0;
  logic [ADDR_W-1:0] host_wr_addr_i = '0;
  logic [ROW_W-1:0]  host_wr_data_i = '0;
  logic              host_wr_gnt_o;
  logic              acc_wr_req_i = 1'b0;
  logic [ADDR_W-1:0] acc_wr_addr_i = '0;
  logic [ROW_W-1:0]  acc_wr_data_i = '0;
  logic              acc_wr_gnt_o;
  logic              act_rd_i = 1'b0;
  logic [ADDR_W-1:0] act_rd_addr_i = '0;
  logic              host_rd_req_i = 1'b0;
  logic [ADDR_W-1:0] host_rd_addr_i = '0;
  logic              host_rd_gnt_o;
  logic              host_rd_valid_o;
  logic              ub_write_o;
  logic [ADDR_W-1:0] ub_addr_wr_o;
  logic [ROW_W-1:0]  ub_data_o;
  logic              ub_read_o;
  logic [ADDR_W-1:0] ub_addr_rd_o;
  logic              rw_conflict_o;

  int tests = 0;
  int fails = 0;

  ub_port_arbiter #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_wr_req_i(host_wr_req_i), .host_wr_addr_i(host_wr_addr_i),
    .host_wr_data_i(host_wr_data_i), .host_wr_gnt_o(host_wr_gnt_o),
    .acc_wr_req_i(acc_wr_req_i), .acc_wr_addr_i(acc_wr_addr_i),
    .acc_wr_data_i(acc_wr_data_i), .acc_wr_gnt_o(acc_wr_gnt_o),
    .act_rd_i(act_rd_i), .act_rd_addr_i(act_rd_addr_i),
    .host_rd_req_i(host_rd_req_i), .host_rd_addr_i(host_rd_addr_i),
    .host_rd_gnt_o(host_rd_gnt_o), .host_rd_valid_o(host_rd_valid_o),
    .ub_write_o(ub_write_o), .ub_addr_wr_o(ub_addr_wr_o), .ub_data_o(ub_data_o),
    .ub_read_o(ub_read_o), .ub_addr_rd_o(ub_addr_rd_o), .rw_conflict_o(rw_conflict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] row(input logic [15:0] t);
    return {32{t}};
  endfunction

  initial begin
    // Reset state
    #1 rst_i = 1'b0;
    #2;
    chk("rst_host_gnt", ROW_W'(host_wr_gnt_o), '0);
    chk("rst_acc_gnt", ROW_W'(acc_wr_gnt_o), '0);
    chk("rst_ub_write", ROW_W'(ub_write_o), '0);
    chk("rst_rd_valid", ROW_W'(host_rd_valid_o), '0);
    chk("rst_conflict", ROW_W'(rw_conflict_o), '0);
    chk("rst_ub_read", ROW_W'(ub_read_o), '0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    tick();

    // Host-only burst of 20 beats, addresses 0..19
    host_wr_req_i  = 1'b1;
    host_wr_addr_i = '0;
    host_wr_data_i = row(16'hA000);
    tick();
    chk("hb_gnt_first", ROW_W'(host_wr_gnt_o), 1);
    chk("hb_no_write_yet", ROW_W'(ub_write_o), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hb_write", ROW_W'(ub_write_o), 1);
      chk("hb_addr", ROW_W'(ub_addr_wr_o), ROW_W'(i));
      chk("hb_data", ub_data_o, row(16'(16'hA000 + i)));
      chk("hb_host_gnt", ROW_W'(host_wr_gnt_o), 1);
      chk("hb_acc_gnt", ROW_W'(acc_wr_gnt_o), 0);
      if (i < 19) begin
        host_wr_addr_i = ADDR_W'(i + 1);
        host_wr_data_i = row(16'(16'hA000 + i + 1));
      end else begin
        host_wr_req_i = 1'b0;
      end
    end
    tick();
    chk("hb_end_gnt", ROW_W'(host_wr_gnt_o), 0);
    chk("hb_end_write", ROW_W'(ub_write_o), 0);

    // Reset mid-burst with a host read in flight
    host_wr_req_i  = 1'b1;
    host_wr_addr_i = 12'h100;
    host_wr_data_i = row(16'h1111);
    host_rd_req_i  = 1'b1;
    host_rd_addr_i = 12'h0CC;
    tick();
    tick();
    tick();
    tick();
    chk("mb_pre_write", ROW_W'(ub_write_o), 1);
    chk("mb_pre_valid", ROW_W'(host_rd_valid_o), 1);
    chk("mb_pre_gnt", ROW_W'(host_wr_gnt_o), 1);
    #2 rst_i = 1'b0;
    #1;
    chk("mb_rst_host_gnt", ROW_W'(host_wr_gnt_o), 0);
    chk("mb_rst_acc_gnt", ROW_W'(acc_wr_gnt_o), 0);
    chk("mb_rst_write", ROW_W'(ub_write_o), 0);
    chk("mb_rst_valid", ROW_W'(host_rd_valid_o), 0);
    host_rd_req_i = 1'b0;
    acc_wr_req_i  = 1'b1;
    acc_wr_addr_i = 12'h200;
    acc_wr_data_i = row(16'h2222);
    @(posedge clk_i);
    #2 rst_i = 1'b1;

    // Contention: 8 host beats, 8 acc beats, then host again, no bubbles
    tick();
    chk("ct_host_first", ROW_W'(host_wr_gnt_o), 1);
    chk("ct_acc_first", ROW_W'(acc_wr_gnt_o), 0);
    chk("ct_no_write", ROW_W'(ub_write_o), 0);
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk("ct_host_gnt", ROW_W'(host_wr_gnt_o), ROW_W'((j < 8) || (j >= 16)));
      chk("ct_acc_gnt", ROW_W'(acc_wr_gnt_o), ROW_W'((j >= 8) && (j < 16)));
      chk("ct_write", ROW_W'(ub_write_o), 1);
      chk("ct_addr", ROW_W'(ub_addr_wr_o), ((j - 1) < 8) ? ROW_W'(12'h100) : ROW_W'(12'h200));
    end
    host_wr_req_i = 1'b0;
    acc_wr_req_i  = 1'b0;
    tick();
    tick();
    chk("ct_idle_gnt", ROW_W'(host_wr_gnt_o | acc_wr_gnt_o), 0);

    // Early release: acc gives up after 3 beats, host takes over next cycle
    acc_wr_req_i  = 1'b1;
    acc_wr_addr_i = 12'h300;
    acc_wr_data_i = row(16'hC000);
    tick();
    chk("er_acc_gnt", ROW_W'(acc_wr_gnt_o), 1);
    host_wr_req_i  = 1'b1;
    host_wr_addr_i = 12'h050;
    host_wr_data_i = row(16'h5050);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("er_acc_write", ROW_W'(ub_write_o), 1);
      chk("er_acc_addr", ROW_W'(ub_addr_wr_o), ROW_W'(12'h300 + k));
      chk("er_acc_hold", ROW_W'(acc_wr_gnt_o), 1);
      acc_wr_addr_i = ADDR_W'(12'h300 + k + 1);
      acc_wr_data_i = row(16'(16'hC000 + k + 1));
    end
    acc_wr_req_i = 1'b0;
    tick();
    chk("er_host_gnt", ROW_W'(host_wr_gnt_o), 1);
    chk("er_acc_off", ROW_W'(acc_wr_gnt_o), 0);
    chk("er_bubble", ROW_W'(ub_write_o), 0);
    tick();
    chk("er_host_write", ROW_W'(ub_write_o), 1);
    chk("er_host_addr", ROW_W'(ub_addr_wr_o), ROW_W'(12'h050));
    host_wr_req_i = 1'b0;
    tick();
    tick();

    // Read priority: activation wins for 4 cycles, then host is granted
    act_rd_i       = 1'b1;
    act_rd_addr_i  = 12'h0AA;
    host_rd_req_i  = 1'b1;
    host_rd_addr_i = 12'h0BB;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rd_host_gnt_blocked", ROW_W'(host_rd_gnt_o), 0);
      chk("rd_read_act", ROW_W'(ub_read_o), 1);
      chk("rd_addr_act", ROW_W'(ub_addr_rd_o), ROW_W'(12'h0AA));
      tick();
      chk("rd_valid_low", ROW_W'(host_rd_valid_o), 0);
    end
    act_rd_i = 1'b0;
    #1;
    chk("rd_host_gnt", ROW_W'(host_rd_gnt_o), 1);
    chk("rd_read_host", ROW_W'(ub_read_o), 1);
    chk("rd_addr_host", ROW_W'(ub_addr_rd_o), ROW_W'(12'h0BB));
    tick();
    chk("rd_valid_high", ROW_W'(host_rd_valid_o), 1);
    host_rd_req_i = 1'b0;
    #1;
    chk("rd_idle_read", ROW_W'(ub_read_o), 0);
    tick();
    chk("rd_valid_drop", ROW_W'(host_rd_valid_o), 0);

    // Conflict: write beat to 0x010, activation read of 0x010 the next cycle
    host_wr_req_i  = 1'b1;
    host_wr_addr_i = 12'h010;
    host_wr_data_i = row(16'h0010);
    tick();
    tick();
    chk("cf_write", ROW_W'(ub_write_o), 1);
    chk("cf_before", ROW_W'(rw_conflict_o), 0);
    host_wr_req_i = 1'b0;
    act_rd_i      = 1'b1;
    act_rd_addr_i = 12'h010;
    tick();
    chk("cf_flag", ROW_W'(rw_conflict_o), 1);
    act_rd_i = 1'b0;
    tick();
    chk("cf_after", ROW_W'(rw_conflict_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
